// File: rtl/alu_feeder.sv
// Feeds queued commands to a byte-serial ALU (opcode byte, then operand bytes),
// waits for the result with a timeout, and buffers results in a small FIFO.
module alu_feeder #(
   parameter int TIMEOUT_CYC = 255,
   parameter int RES_DEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_val,
   output logic        cmd_rdy,
   input  logic [7:0]  cmd_op,
   input  logic [63:0] cmd_opd,
   input  logic [3:0]  cmd_nopd,
   output logic        alu_ctl,
   output logic [7:0]  alu_dat,
   input  logic        alu_ready,
   input  logic [31:0] alu_result,
   input  logic        cfg_wr,
   input  logic [4:0]  cfg_len,
   output logic [4:0]  frame_len,
   output logic        frame_len_val,
   output logic        res_val,
   input  logic        res_rdy,
   output logic [31:0] res_dat,
   output logic        busy,
   output logic        err_timeout,
   output logic [1:0]  dbg_state
);

   localparam int CW  = $clog2(RES_DEPTH + 1);
   localparam int PW  = $clog2(RES_DEPTH);
   localparam int WCW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, OPC, OPD, WAIT} state_t;

   // Handshakes: cmd accepted on an edge with cmd_val && cmd_rdy; a result is
   // popped on an edge with res_val && res_rdy. Neither side may retract val early.
   state_t          state_q, state_nxt;
   logic [63:0]     opd_q, opd_nxt;
   logic [3:0]      left_q, left_nxt;
   logic [WCW-1:0]  wcnt_q, wcnt_nxt;
   logic            ctl_nxt;
   logic [7:0]      dat_nxt;
   logic            rdy_nxt;
   logic            push, pop, accept, tmo;
   logic [CW-1:0]   cnt_q, cnt_nxt;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [31:0]     mem [RES_DEPTH];

   always_comb begin
      state_nxt = state_q;
      opd_nxt   = opd_q;
      left_nxt  = left_q;
      wcnt_nxt  = wcnt_q;
      ctl_nxt   = 1'b0;
      dat_nxt   = 8'h00;
      push      = 1'b0;
      tmo       = 1'b0;
      accept    = cmd_val && cmd_rdy;
      pop       = (cnt_q != '0) && res_rdy;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_nxt = OPC;
               ctl_nxt   = 1'b1;
               dat_nxt   = cmd_op;
               opd_nxt   = cmd_opd;
               left_nxt  = (cmd_nopd > 4'd8) ? 4'd8 : cmd_nopd;
            end
         end
         // Outputs are registered, so the byte shown next cycle is chosen here.
         OPC, OPD: begin
            if (left_q != 4'd0) begin
               state_nxt = OPD;
               dat_nxt   = opd_q[7:0];
               opd_nxt   = {8'h00, opd_q[63:8]};
               left_nxt  = left_q - 4'd1;
            end else begin
               state_nxt = WAIT;
               wcnt_nxt  = '0;
            end
         end
         WAIT: begin
            if ((wcnt_q != '0) && alu_ready) begin
               push      = 1'b1;
               state_nxt = IDLE;
            end else if (wcnt_q == WCW'(TIMEOUT_CYC - 1)) begin
               tmo       = 1'b1;
               state_nxt = IDLE;
            end else begin
               wcnt_nxt  = wcnt_q + WCW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      cnt_nxt = cnt_q;
      if (push && !pop)      cnt_nxt = cnt_q + CW'(1);
      else if (pop && !push) cnt_nxt = cnt_q - CW'(1);
      rdy_nxt = (state_nxt == IDLE) && alu_ready && (cnt_nxt < CW'(RES_DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         opd_q         <= '0;
         left_q        <= '0;
         wcnt_q        <= '0;
         alu_ctl       <= 1'b0;
         alu_dat       <= 8'h00;
         cmd_rdy       <= 1'b0;
         err_timeout   <= 1'b0;
         frame_len     <= '0;
         frame_len_val <= 1'b0;
         cnt_q         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
      end else begin
         state_q       <= state_nxt;
         opd_q         <= opd_nxt;
         left_q        <= left_nxt;
         wcnt_q        <= wcnt_nxt;
         alu_ctl       <= ctl_nxt;
         alu_dat       <= dat_nxt;
         cmd_rdy       <= rdy_nxt;
         frame_len_val <= cfg_wr;
         cnt_q         <= cnt_nxt;
         if (tmo)    err_timeout <= 1'b1;
         if (cfg_wr) frame_len   <= cfg_len;
         if (push) begin
            mem[wr_ptr] <= alu_result;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   assign res_val   = (cnt_q != '0);
   assign res_dat   = mem[rd_ptr];
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_feeder.sv
// Bench for alu_feeder: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based transaction model.
module tb_alu_feeder;

   localparam int TMO   = 4;
   localparam int DEPTH = 2;

   logic        clk, rst;
   logic        cmd_val, cmd_rdy;
   logic [7:0]  cmd_op;
   logic [63:0] cmd_opd;
   logic [3:0]  cmd_nopd;
   logic        alu_ctl;
   logic [7:0]  alu_dat;
   logic        alu_ready;
   logic [31:0] alu_result;
   logic        cfg_wr;
   logic [4:0]  cfg_len;
   logic [4:0]  frame_len;
   logic        frame_len_val;
   logic        res_val, res_rdy;
   logic [31:0] res_dat;
   logic        busy, err_timeout;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   alu_feeder #(.TIMEOUT_CYC(TMO), .RES_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_opd(cmd_opd),
      .cmd_nopd(cmd_nopd), .alu_ctl(alu_ctl), .alu_dat(alu_dat),
      .alu_ready(alu_ready), .alu_result(alu_result),
      .cfg_wr(cfg_wr), .cfg_len(cfg_len), .frame_len(frame_len),
      .frame_len_val(frame_len_val), .res_val(res_val), .res_rdy(res_rdy),
      .res_dat(res_dat), .busy(busy), .err_timeout(err_timeout),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next falling edge; inputs change only here.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] op, input logic [3:0] n, input logic [63:0] opd);
      cmd_val  = 1'b1;
      cmd_op   = op;
      cmd_nopd = n;
      cmd_opd  = opd;
   endtask

   // ---------------- behavioural model ----------------
   logic [8:0]  m_byteq [$];
   logic [31:0] m_resq  [$];
   logic [8:0]  m_cur;
   bit          m_busy, m_waiting, m_rdy, m_err, m_flval;
   int          m_wait_n;
   logic [4:0]  m_flen;
   int          m_n;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_byteq.delete();
         m_resq.delete();
         m_cur = '0; m_busy = 0; m_waiting = 0; m_rdy = 0; m_err = 0;
         m_flval = 0; m_flen = '0; m_wait_n = 0;
      end else begin
         if (m_resq.size() != 0 && res_rdy) void'(m_resq.pop_front());
         if (cmd_val && m_rdy) begin
            m_cur  = {1'b1, cmd_op};
            m_busy = 1;
            m_byteq.delete();
            m_n = (cmd_nopd > 4'd8) ? 8 : int'(cmd_nopd);
            for (int i = 0; i < m_n; i++) m_byteq.push_back({1'b0, cmd_opd[8*i +: 8]});
         end else if (m_busy && !m_waiting) begin
            if (m_byteq.size() != 0) m_cur = m_byteq.pop_front();
            else begin
               m_cur = '0; m_waiting = 1; m_wait_n = 0;
            end
         end else if (m_waiting) begin
            if (m_wait_n >= 1 && alu_ready) begin
               m_resq.push_back(alu_result);
               m_busy = 0; m_waiting = 0;
            end else if (m_wait_n + 1 == TMO) begin
               m_err = 1; m_busy = 0; m_waiting = 0;
            end else m_wait_n++;
         end
         m_rdy = !m_busy && alu_ready && (m_resq.size() < DEPTH);
         if (cfg_wr) m_flen = cfg_len;
         m_flval = cfg_wr;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_rdy", cmd_rdy, m_rdy);
         chk("alu_ctl", alu_ctl, m_cur[8]);
         chk("alu_dat", alu_dat, m_cur[7:0]);
         chk("busy", busy, m_busy);
         chk("res_val", res_val, m_resq.size() != 0);
         if (m_resq.size() != 0) chk("res_dat", res_dat, m_resq[0]);
         chk("err_timeout", err_timeout, m_err);
         chk("frame_len", frame_len, m_flen);
         chk("frame_len_val", frame_len_val, m_flval);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; cmd_val = 0; cmd_op = '0; cmd_opd = '0; cmd_nopd = '0;
      alu_ready = 0; alu_result = '0; cfg_wr = 0; cfg_len = '0; res_rdy = 0;
      cyc(); cyc();
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_ctl", alu_ctl, 0);
      chk("rst_alu_dat", alu_dat, 0);
      chk("rst_res_val", res_val, 0);
      chk("rst_res_dat", res_dat, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_flen", frame_len, 0);
      chk("rst_flval", frame_len_val, 0);
      chk_en = 1'b1;
      alu_ready = 1; rst = 0;
      cyc();
      chk("rdy_after_rst", cmd_rdy, 1);

      // opcode 0x21 with two operand bytes, then 3 low WAIT cycles
      send(8'h21, 4'd2, 64'hBBAA);
      cyc(); cmd_val = 0; alu_ready = 0;
      chk("s1_ctl0", alu_ctl, 1); chk("s1_dat0", alu_dat, 8'h21); chk("s1_busy", busy, 1);
      chk("s1_rdy_low", cmd_rdy, 0);
      cyc(); chk("s1_ctl1", alu_ctl, 0); chk("s1_dat1", alu_dat, 8'hAA);
      cyc(); chk("s1_ctl2", alu_ctl, 0); chk("s1_dat2", alu_dat, 8'hBB);
      cyc(); chk("s1_wait_ctl", alu_ctl, 0); chk("s1_wait_dat", alu_dat, 0);
      repeat (3) cyc();
      alu_ready = 1; alu_result = 32'hDEADBEEF;
      cyc();
      chk("s2_res_val", res_val, 1); chk("s2_res_dat", res_dat, 32'hDEADBEEF);
      chk("s2_busy", busy, 0); chk("s2_rdy", cmd_rdy, 1);

      // zero-operand command fills the buffer
      send(8'h5A, 4'd0, 64'h0); alu_result = 32'h12345678;
      cyc(); cmd_val = 0;
      chk("s3_ctl", alu_ctl, 1); chk("s3_dat", alu_dat, 8'h5A);
      cyc(); chk("s3_wait_ctl", alu_ctl, 0); chk("s3_wait_busy", busy, 1);
      cyc(); chk("s3_ready_ignored_c0", busy, 1);
      cyc(); chk("s3_done", busy, 0); chk("s3_full_rdy", cmd_rdy, 0);
      chk("s3_head", res_dat, 32'hDEADBEEF);
      res_rdy = 1;
      cyc(); res_rdy = 0;
      chk("s3_pop_rdy", cmd_rdy, 1); chk("s3_pop_head", res_dat, 32'h12345678);

      // nopd=12 clamps to 8 operand bytes; completion coincides with a pop
      send(8'h77, 4'd12, 64'h0807060504030201); alu_result = 32'hCAFEF00D;
      cyc(); cmd_val = 0;
      chk("s4_ctl", alu_ctl, 1); chk("s4_dat", alu_dat, 8'h77);
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("s4_opd_ctl", alu_ctl, 0);
         chk("s4_opd_dat", alu_dat, 64'(i + 1));
      end
      cyc(); chk("s4_wait_ctl", alu_ctl, 0); chk("s4_wait_dat", alu_dat, 0);
      cyc(); res_rdy = 1;
      cyc(); res_rdy = 0;
      chk("s4_pushpop_val", res_val, 1); chk("s4_pushpop_dat", res_dat, 32'hCAFEF00D);
      chk("s4_pushpop_rdy", cmd_rdy, 1);

      // timeout with alu_ready held low
      send(8'h40, 4'd0, 64'h0);
      cyc(); cmd_val = 0; alu_ready = 0;
      repeat (4) cyc();
      chk("s5_c3_busy", busy, 1); chk("s5_c3_err", err_timeout, 0);
      cyc();
      chk("s5_err", err_timeout, 1); chk("s5_idle", busy, 0);
      chk("s5_nopush", res_dat, 32'hCAFEF00D);
      alu_ready = 1;
      cyc(); cyc();
      chk("s5_sticky", err_timeout, 1);

      // frame length write during OPD, then reset mid-command
      send(8'h41, 4'd8, 64'h1122334455667788);
      cyc(); cmd_val = 0;
      cyc(); cfg_wr = 1; cfg_len = 5'd17;
      cyc(); cfg_wr = 0;
      chk("s6_flen", frame_len, 17); chk("s6_flval", frame_len_val, 1);
      cyc();
      chk("s6_flval_drop", frame_len_val, 0); chk("s6_flen_hold", frame_len, 17);
      chk("s6_in_opd", busy, 1);
      @(posedge clk); #2 rst = 1;
      #1;
      chk("s6_rst_ctl", alu_ctl, 0); chk("s6_rst_busy", busy, 0);
      chk("s6_rst_dat", alu_dat, 0); chk("s6_rst_flen", frame_len, 0);
      chk("s6_rst_err", err_timeout, 0); chk("s6_rst_resval", res_val, 0);
      chk("s6_rst_rdy", cmd_rdy, 0);
      cyc(); rst = 0;
      cyc();
      chk("s6_resume_rdy", cmd_rdy, 1); chk("s6_resume_busy", busy, 0);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         cyc();
         rst        = ($urandom_range(0, 399) == 0);
         cmd_val    = 1'($urandom_range(0, 1));
         cmd_op     = 8'($urandom);
         cmd_opd    = {$urandom, $urandom};
         cmd_nopd   = 4'($urandom_range(0, 15));
         alu_ready  = ($urandom_range(0, 9) < 7);
         alu_result = $urandom;
         res_rdy    = 1'($urandom_range(0, 1));
         cfg_wr     = ($urandom_range(0, 4) == 0);
         cfg_len    = 5'($urandom);
      end
      cyc(); rst = 0; cmd_val = 0;
      repeat (20) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
